// File: rtl/multi_cycle_ctrl.sv
// Main control FSM for the multi-cycle CPU datapath.
// Steps each instruction through fetch/decode/execute/memory/write-back.
module multi_cycle_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_J     = 6'h02,
    parameter logic [5:0] OP_ADDI  = 6'h08,
    parameter int         CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             instr_done,
    output logic             halted,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;
    localparam logic [3:0] S_HALT   = 4'd12;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [3:0] nxt;
    logic       is_rtype, is_lw, is_sw, is_beq, is_j, is_addi;

    assign is_rtype = (opcode == OP_RTYPE);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_j     = (opcode == OP_J);
    assign is_addi  = (opcode == OP_ADDI);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_FETCH;
            instr_cnt <= '0;
        end else begin
            state <= nxt;
            if (instr_done)
                instr_cnt <= instr_cnt + CNT_ONE;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            S_FETCH:  if (mem_ready) nxt = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    is_lw, is_sw: nxt = S_MEMADR;
                    is_rtype:     nxt = S_EXEC;
                    is_beq:       nxt = S_BRANCH;
                    is_j:         nxt = S_JUMP;
                    is_addi:      nxt = S_ADDIEX;
                    default:      nxt = S_HALT;
                endcase
            end
            S_MEMADR: nxt = is_sw ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) nxt = S_MEMWB;
            S_MEMWR:  if (mem_ready) nxt = S_FETCH;
            S_MEMWB:  nxt = S_FETCH;
            S_EXEC:   nxt = S_ALUWB;
            S_ALUWB:  nxt = S_FETCH;
            S_ADDIEX: nxt = S_ADDIWB;
            S_ADDIWB: nxt = S_FETCH;
            S_BRANCH: nxt = S_FETCH;
            S_JUMP:   nxt = S_FETCH;
            S_HALT:   nxt = S_HALT;
            default:  nxt = S_FETCH;
        endcase
    end

    always_comb begin
        pc_en      = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 2'd0;
        pc_source  = 2'd0;
        instr_done = 1'b0;
        halted     = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            // branch target is precomputed while the opcode decodes
            S_DECODE: alu_src_b = 2'd3;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd2;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'd1;
                pc_source  = 2'd1;
                pc_en      = alu_zero;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_source  = 2'd2;
                pc_en      = 1'b1;
                instr_done = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: instruction-path model plus directed
// scenarios and randomized opcode / mem_ready / alu_zero traffic.
module tb_multi_cycle_ctrl;

    localparam int CW = 4;

    localparam int M_FETCH  = 0;
    localparam int M_DECODE = 1;
    localparam int M_MEMADR = 2;
    localparam int M_MEMRD  = 3;
    localparam int M_MEMWB  = 4;
    localparam int M_MEMWR  = 5;
    localparam int M_EXEC   = 6;
    localparam int M_ALUWB  = 7;
    localparam int M_BRANCH = 8;
    localparam int M_JUMP   = 9;
    localparam int M_ADDIEX = 10;
    localparam int M_ADDIWB = 11;
    localparam int M_HALT   = 12;

    typedef struct packed {
        logic       pc_en;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       halted;
    } out_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [5:0]    opcode = 6'h00;
    logic          alu_zero = 1'b0;
    logic          mem_ready = 1'b1;
    logic          pc_en, i_or_d, mem_read, mem_write, ir_write;
    logic          mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]    alu_src_b, alu_op, pc_source;
    logic          instr_done, halted;
    logic [3:0]    state;
    logic [CW-1:0] instr_cnt;

    multi_cycle_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .instr_done(instr_done),
        .halted(halted), .state(state), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    int            errors = 0;
    int            checks = 0;
    int            path[$];
    int            idx;
    logic [CW-1:0] mcnt;
    logic [63:0]   trace;
    int            done_seen;
    logic          last_pc_en, last_mem_write;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic bit stalls(int s);
        return s == M_FETCH || s == M_MEMRD || s == M_MEMWR;
    endfunction

    function automatic bit retiring();
        int cur = path[idx];
        return path.size() > 2 && idx == path.size() - 1 &&
               cur != M_HALT && (cur != M_MEMWR || mem_ready);
    endfunction

    function automatic out_t expect_out(int st, logic rdy, logic z, logic ret);
        out_t o = '0;
        case (st)
            M_FETCH:  begin
                o.mem_read = 1; o.alu_src_b = 1;
                o.ir_write = rdy; o.pc_en = rdy;
            end
            M_DECODE: o.alu_src_b = 3;
            M_MEMADR: begin o.alu_src_a = 1; o.alu_src_b = 2; end
            M_MEMRD:  begin o.mem_read = 1; o.i_or_d = 1; end
            M_MEMWB:  begin o.reg_write = 1; o.mem_to_reg = 1; end
            M_MEMWR:  begin o.mem_write = 1; o.i_or_d = 1; end
            M_EXEC:   begin o.alu_src_a = 1; o.alu_op = 2; end
            M_ALUWB:  begin o.reg_write = 1; o.reg_dst = 1; end
            M_ADDIEX: begin o.alu_src_a = 1; o.alu_src_b = 2; end
            M_ADDIWB: o.reg_write = 1;
            M_BRANCH: begin
                o.alu_src_a = 1; o.alu_op = 1;
                o.pc_source = 1; o.pc_en = z;
            end
            M_JUMP:   begin o.pc_source = 2; o.pc_en = 1; end
            M_HALT:   o.halted = 1;
            default:  ;
        endcase
        o.instr_done = ret;
        return o;
    endfunction

    task automatic push_route(logic [5:0] op);
        case (op)
            6'h23:   begin path.push_back(M_MEMADR); path.push_back(M_MEMRD);
                           path.push_back(M_MEMWB); end
            6'h2B:   begin path.push_back(M_MEMADR); path.push_back(M_MEMWR); end
            6'h00:   begin path.push_back(M_EXEC); path.push_back(M_ALUWB); end
            6'h04:   path.push_back(M_BRANCH);
            6'h02:   path.push_back(M_JUMP);
            6'h08:   begin path.push_back(M_ADDIEX); path.push_back(M_ADDIWB); end
            default: path.push_back(M_HALT);
        endcase
    endtask

    task automatic model_reset();
        path = '{M_FETCH, M_DECODE};
        idx  = 0;
        mcnt = '0;
    endtask

    // compare at negedge+1, then advance the model across the posedge
    task automatic tick();
        int   cur;
        bit   ret;
        out_t act;
        #1;
        cur = path[idx];
        ret = retiring();
        act = {pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_done, halted};
        chk("state", 64'(state), 64'(cur));
        chk("outputs", 64'(act), 64'(expect_out(cur, mem_ready, alu_zero, ret)));
        chk("instr_cnt", 64'(instr_cnt), 64'(mcnt));
        chk("rd_wr_excl", 64'(mem_read & mem_write), 64'd0);
        chk("ir_write_fetch", 64'(ir_write && state != 4'd0), 64'd0);
        trace = {trace[59:0], state};
        if (instr_done) done_seen++;
        last_pc_en     = pc_en;
        last_mem_write = mem_write;
        @(posedge clk);
        if (!rst) model_reset();
        else if (cur == M_HALT) ;
        else if (stalls(cur) && !mem_ready) ;
        else if (ret) begin
            mcnt = mcnt + 1'b1;
            path = '{M_FETCH, M_DECODE};
            idx  = 0;
        end else begin
            if (cur == M_DECODE) push_route(opcode);
            idx++;
        end
        @(negedge clk);
    endtask

    task automatic cyc(logic r, logic rdy, logic z);
        rst = r; mem_ready = rdy; alu_zero = z;
        tick();
    endtask

    logic [5:0] ops [7] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F};

    initial begin
        int halt_run;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_cnt", 64'(instr_cnt), 64'd0);

        opcode = 6'h00; trace = '0;
        repeat (4) cyc(1, 1, 0);
        chk("rtype_seq", trace[15:0], 64'h0167);
        chk("rtype_cnt", 64'(instr_cnt), 64'd1);

        opcode = 6'h23; trace = '0;
        repeat (3) cyc(1, 1, 0);
        repeat (3) cyc(1, 0, 0);
        repeat (2) cyc(1, 1, 0);
        chk("lw_stall_seq", trace[31:0], 64'h01233334);
        chk("lw_cnt", 64'(instr_cnt), 64'd2);

        opcode = 6'h04;
        repeat (3) cyc(1, 1, 1);
        chk("beq_taken_pc_en", 64'(last_pc_en), 64'd1);
        repeat (3) cyc(1, 1, 0);
        chk("beq_not_taken_pc_en", 64'(last_pc_en), 64'd0);
        chk("beq_cnt", 64'(instr_cnt), 64'd4);

        opcode = 6'h3F;
        repeat (2) cyc(1, 1, 0);
        done_seen = 0;
        repeat (20) cyc(1, $urandom_range(0, 1) == 1, 0);
        chk("halt_halted", 64'(halted), 64'd1);
        chk("halt_state", 64'(state), 64'd12);
        chk("halt_no_done", 64'(done_seen), 64'd0);
        opcode = 6'h00;
        cyc(0, 1, 0);
        chk("halt_rst_state", 64'(state), 64'd0);
        chk("halt_rst_cnt", 64'(instr_cnt), 64'd0);

        opcode = 6'h2B;
        repeat (3) cyc(1, 1, 0);
        cyc(1, 0, 0);
        done_seen = 0;
        cyc(0, 0, 0);
        chk("memwr_stall_write", 64'(last_mem_write), 64'd1);
        chk("memwr_rst_state", 64'(state), 64'd0);
        chk("memwr_rst_write", 64'(mem_write), 64'd0);
        chk("memwr_rst_cnt", 64'(instr_cnt), 64'd0);
        chk("memwr_rst_no_done", 64'(done_seen), 64'd0);

        opcode = 6'h02;
        for (int n = 0; n < 16; n++) begin
            repeat (3) cyc(1, 1, 0);
            if (n == 14) chk("j_cnt_15", 64'(instr_cnt), 64'hF);
        end
        chk("j_cnt_wrap", 64'(instr_cnt), 64'd0);
        chk("j_state", 64'(state), 64'd0);

        halt_run = 0;
        for (int c = 0; c < 2000; c++) begin
            logic r;
            if (idx == 0)
                opcode = ($urandom_range(0, 19) == 0) ? ops[6]
                                                     : ops[$urandom_range(0, 5)];
            halt_run = (path[idx] == M_HALT) ? halt_run + 1 : 0;
            r = !($urandom_range(0, 99) == 0 || halt_run > 3);
            cyc(r, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Main control FSM for the multi-period CPU datapath.
- Sequences each instruction through fetch, decode, execute, memory and write-back steps.
- Drives every datapath mux select and write enable, and stalls on a memory ready handshake.
- Counts retired instructions and halts on an illegal opcode; the top-level CPU instantiates it beside the shared instruction/data memory, register file and ALU.

Parameters:
- OP_RTYPE, 6'h00, R-type opcode (add/sub/and/or/slt via funct; ALU decoding is not done here)
- OP_LW, 6'h23, load word
- OP_SW, 6'h2B, store word
- OP_BEQ, 6'h04, branch if equal
- OP_J, 6'h02, jump
- OP_ADDI, 6'h08, add immediate
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low
- opcode  in  6  IR[31:26], valid from DECODE onward
- alu_zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- pc_en  out  1  PC register load enable
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load enable
- mem_to_reg  out  1  write-back data select: 1 = MDR
- reg_dst  out  1  destination select: 1 = rd, 0 = rt
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A reg
- alu_src_b  out  2  ALU B select: 0 = B reg, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2
- alu_op  out  2  ALU op class: 0 = add, 1 = sub, 2 = funct
- pc_source  out  2  next-PC select: 0 = ALU result, 1 = ALUOut, 2 = jump target
- instr_done  out  1  one-cycle pulse when an instruction retires
- halted  out  1  high in the HALT state
- state  out  4  current state encoding, for debug
- instr_cnt  out  CNT_W  count of retired instructions

Behaviour:
- Reset: when rst==0 at a rising edge, state becomes FETCH and instr_cnt becomes 0.
  - All outputs depend only on state and inputs, so after reset they take FETCH values with mem_ready gating.
  - Reset wins over every other event, including mid-instruction and mid-stall.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, HALT=12. Encodings 13–15 go to FETCH on the next edge with all enables 0.
- Defaults: every output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0.
  - If mem_ready: ir_write=1, pc_en=1, next state DECODE.
  - Else: stay in FETCH with ir_write=0 and pc_en=0.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=3, alu_op=0 (precomputes the branch target).
  - Next state by opcode: LW or SW → MEMADR; RTYPE → EXEC; BEQ → BRANCH; J → JUMP; ADDI → ADDIEX; any other opcode → HALT.
- MEMADR: alu_src_a=1, alu_src_b=2, alu_op=0. Next state is MEMRD for LW, MEMWR for SW.
- MEMRD: mem_read=1, i_or_d=1. Stay until mem_ready, then go to MEMWB.
- MEMWR:
  - Outputs: mem_write=1, i_or_d=1.
  - Stay until mem_ready, then retire (instr_done=1 in that cycle) and go to FETCH.
  - mem_write stays high for the whole stall.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Retire, then go to FETCH.
- EXEC: alu_src_a=1, alu_src_b=0, alu_op=2. Next state ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Retire, then go to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=2, alu_op=0. Next state ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Retire, then go to FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=0, alu_op=1, pc_source=1, pc_en=alu_zero.
  - Retire whether taken or not, then go to FETCH.
- JUMP: pc_source=2, pc_en=1. Retire, then go to FETCH.
- HALT:
  - All enables 0 and halted=1. Stays in HALT until reset.
  - Not counted as a retired instruction.
- Retire: instr_done=1 for exactly one cycle (the final cycle of the instruction), and instr_cnt increments on that edge. The counter wraps from all-ones to 0 without saturating.
- Cycle counts with mem_ready always 1:
  - LW = 5, SW = 4, R-type = 4, ADDI = 4, BEQ = 3, J = 3.
  - Each stalled cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Invariants:
  - mem_read and mem_write are never both high.
  - ir_write is only ever high in FETCH.
  - pc_en is high at most once per instruction beyond the FETCH update (BRANCH taken or JUMP).

Test Plan:
- Reset then release with mem_ready=1 and opcode=6'h00 (R-type) held → state sequence 0,1,6,7,0; instr_done pulses in the ALUWB cycle; instr_cnt=1 after 4 cycles; reg_write=1 and reg_dst=1 in ALUWB.
- LW with mem_ready low for 3 cycles in MEMRD → state sequence 0,1,2,3,3,3,3,4,0 (8 cycles); mem_read=1 and i_or_d=1 throughout the stall; reg_write=1 only in MEMWB.
- BEQ with alu_zero=1, then BEQ with alu_zero=0 → pc_en=1 in the BRANCH cycle only when zero is set; both retire; instr_cnt increments by 2.
- Opcode 6'h3F → DECODE goes to HALT; halted=1 and stays 1 for 20 cycles; instr_done never pulses; then rst=0 for one edge → state=0, instr_cnt=0.
- Assert rst=0 mid-stall in MEMWR (mem_write=1) → on the next edge state=0 and mem_write=0; instr_cnt=0; no instr_done pulse.
- Preload instr_cnt to all-ones via 2^CNT_W retirements (use CNT_W=4 for 16 J instructions) → counter wraps to 0; each J takes 3 cycles with pc_source=2 and pc_en=1 in the JUMP cycle.
